// File: rtl/req_arbiter.sv
// Grant arbiter for N requesters sharing one resource, with a hold limit that
// forces release. Define RR_PRIORITY_EN for rotating priority (fixed priority otherwise).
module req_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDW      = $clog2(N),
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  localparam int unsigned HCW = $clog2(MAX_HOLD);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_d;
  logic [HCW-1:0] hold_cnt, hold_cnt_d;
  logic [N-1:0]   gnt_d;
  logic [IDW-1:0] gnt_id_d;
  logic           gnt_valid_d;
  logic           timeout_d;
  logic [IDW-1:0] win_id;

`ifdef RR_PRIORITY_EN
  logic [IDW-1:0] last_id, last_id_d;

  // Downward search with wrap starting just below the last owner.
  always_comb begin : pick_rr
    int unsigned start;
    int unsigned idx;
    logic        found;
    win_id = '0;
    found  = 1'b0;
    start  = (last_id == '0) ? (N - 1) : (32'(last_id) - 1);
    for (int unsigned i = 0; i < N; i++) begin
      idx = (start + N - i) % N;
      if (!found && req[IDW'(idx)]) begin
        win_id = IDW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin : last_next
    last_id_d = last_id;
    if (state == IDLE && en && (|req)) last_id_d = win_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin : last_reg
    if (!rst_n) last_id <= '0;
    else        last_id <= last_id_d;
  end
`else
  // Highest set index wins.
  always_comb begin : pick_fixed
    win_id = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[IDW'(i)]) win_id = IDW'(i);
    end
  end
`endif

  // Next state and next registered outputs.
  always_comb begin : next_state
    state_d     = state;
    hold_cnt_d  = hold_cnt;
    gnt_d       = gnt;
    gnt_id_d    = gnt_id;
    gnt_valid_d = gnt_valid;
    timeout_d   = 1'b0;
    case (state)
      IDLE: begin
        if (en && (|req)) begin
          state_d         = BUSY;
          gnt_d           = '0;
          gnt_d[win_id]   = 1'b1;
          gnt_id_d        = win_id;
          gnt_valid_d     = 1'b1;
          hold_cnt_d      = '0;
        end
      end
      BUSY: begin
        if (!en || !req[gnt_id] || (hold_cnt == HCW'(MAX_HOLD - 1))) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          // Only the hold limit, not disable or release, signals a timeout.
          timeout_d   = en && req[gnt_id];
        end else begin
          hold_cnt_d = hold_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_d;
      hold_cnt  <= hold_cnt_d;
      gnt       <= gnt_d;
      gnt_id    <= gnt_id_d;
      gnt_valid <= gnt_valid_d;
      timeout   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_req_arbiter.sv
// Bench for req_arbiter: directed scenarios plus random traffic against an
// ownership-level reference model.
module tb_req_arbiter;

  localparam int N        = 8;
  localparam int IDW      = 3;
  localparam int MAX_HOLD = 16;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           timeout;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: current owner (-1 = none), cycles granted so far,
  // previous owner, and whether the last edge was a forced release.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 0;
  bit m_to    = 1'b0;

  req_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef RR_PRIORITY_EN
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last - k + N) % N;
      if (r[c]) return c;
    end
`else
    for (int c = N - 1; c >= 0; c--) if (r[c]) return c;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge();
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (en && (req != '0)) begin
        m_owner = pick(req, m_last);
        m_last  = m_owner;
        m_held  = 1;
      end
    end else if (!en || !req[m_owner]) begin
      m_owner = -1;
    end else if (m_held == MAX_HOLD) begin
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] eg;
    eg = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    check({tag, ".gnt"},       32'(gnt),       eg);
    check({tag, ".gnt_id"},    32'(gnt_id),    (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), (m_owner < 0) ? 32'd0 : 32'd1);
    check({tag, ".timeout"},   32'(timeout),   32'(m_to));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  // Asserts reset between edges, checks outputs clear at once, releases after one edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model({tag, ".async"});
    @(posedge clk);
    #1;
    check_model({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int cnt;
    int to_at;
    int seq[$];
    int exp_id;

    // Test 1: reset state, checked before any clock edge.
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'hFF;
    #1;
    model_reset();
    check("t1_gnt", 32'(gnt), 32'd0);
    check("t1_gnt_id", 32'(gnt_id), 32'd0);
    check("t1_gnt_valid", 32'(gnt_valid), 32'd0);
    check("t1_timeout", 32'(timeout), 32'd0);
    @(posedge clk);
    #1;
    check_model("t1_held");
    rst_n = 1'b1;

    // Test 2: two requesters, higher index wins after one edge.
    req = 8'b0010_0100;
    step("t2");
    check("t2_gnt_const", 32'(gnt), 32'h20);
    check("t2_id_const", 32'(gnt_id), 32'd5);

    // Test 3: owner releases, one idle cycle, then requester 2.
    req = 8'b0000_0100;
    step("t3a");
    check("t3_idle_gnt", 32'(gnt), 32'd0);
    step("t3b");
    check("t3_id_const", 32'(gnt_id), 32'd2);

    // Test 5: disable while busy clears grant without timeout.
    req = 8'b0000_0000;
    step("t5_rel");
    step("t5_idle");
    req = 8'b0010_0100;
    step("t5_grant");
    en = 1'b0;
    step("t5_dis");
    check("t5_gnt_zero", 32'(gnt), 32'd0);
    check("t5_to_zero", 32'(timeout), 32'd0);
    for (int i = 0; i < 4; i++) step("t5_hold_off");
    en = 1'b1;

    // Test 4: single requester held 20 cycles; 16 granted, then timeout, then regrant.
    req = '0;
    step("t4_pre");
    step("t4_pre");
    req   = 8'h80;
    cnt   = 0;
    to_at = 0;
    for (int i = 1; i <= 20; i++) begin
      step("t4");
      if (gnt == 8'h80 && to_at == 0) cnt++;
      if (timeout === 1'b1 && to_at == 0) to_at = i;
    end
    check("t4_grant_cycles", 32'(cnt), 32'd16);
    check("t4_timeout_cycle", 32'(to_at), 32'd17);

    // Test 6: all requesting, owners hold until timeout; order of new grants.
    do_reset("t6_rst");
    req = 8'hFF;
    seq.delete();
    for (int i = 0; i < 10 * (MAX_HOLD + 1); i++) begin
      step("t6");
      if (timeout === 1'b0 && gnt_valid === 1'b1 && seq.size() < 10 &&
          (i == 0 || cnt == 0)) seq.push_back(int'(gnt_id));
      cnt = int'(gnt_valid);
    end
    check("t6_count", 32'(seq.size()), 32'd10);
    for (int k = 0; k < seq.size(); k++) begin
`ifdef RR_PRIORITY_EN
      exp_id = (N - 1 - k + 2 * N) % N;
`else
      exp_id = N - 1;
`endif
      check($sformatf("t6_order%0d", k), 32'(seq[k]), 32'(exp_id));
    end

    // Reset mid-grant, then random traffic.
    req = 8'h10;
    step("rm_grant");
    do_reset("rm_rst");
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) req = N'($urandom);
        else req = N'(1) << $urandom_range(0, N - 1);
      end
      if ($urandom_range(0, 7) == 0) req = '0;
      if ($urandom_range(0, 149) == 0) do_reset("rnd_rst");
      else step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
